// File: rtl/pcpi_matmul2x2.sv
// PCPI coprocessor holding two signed 2x2 matrices and computing C = A*B on one shared MAC.
// Define MATMUL_SATURATE_EN to clamp each C element to the signed 2*DATA_W-bit range at writeback.
module pcpi_matmul2x2 #(
    parameter int         DATA_W = 8,
    parameter int         ACC_W  = 2*DATA_W+1,
    parameter logic [6:0] OPCODE = 7'b0001011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    output logic        pcpi_ready,
    output logic        pcpi_wr,
    output logic        pcpi_wait,
    output logic [31:0] pcpi_rd,
    output logic        busy,
    output logic        err_illegal
);

    localparam int PROD_W = 2*DATA_W;

    localparam logic [2:0] F_LOADA = 3'b000;
    localparam logic [2:0] F_LOADB = 3'b001;
    localparam logic [2:0] F_MUL   = 3'b010;
    localparam logic [2:0] F_READC = 3'b011;
    localparam logic [2:0] F_CLEAR = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_RESP, S_MAC} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [2:0]                 r_funct3;
    logic [1:0]                 r_idx;
    logic [DATA_W-1:0]          r_imm;
    logic [2:0]                 r_count;
    logic signed [PROD_W-1:0]   r_acc;
    logic [DATA_W-1:0]          r_a [0:3];
    logic [DATA_W-1:0]          r_b [0:3];
    logic [ACC_W-1:0]           r_c [0:3];
    logic                       r_err;

    logic                       w_legal;
    logic                       w_rowI;
    logic                       w_colJ;
    logic                       w_k;
    logic signed [DATA_W-1:0]   w_aOp;
    logic signed [DATA_W-1:0]   w_bOp;
    logic signed [PROD_W-1:0]   w_prod;
    logic [ACC_W-1:0]           w_sum;
    logic [ACC_W-1:0]           w_cNew;
    logic                       w_unused;

    assign w_unused = ^{pcpi_insn[11:7], pcpi_insn[23:17]};
    assign w_legal  = (pcpi_insn[6:0] == OPCODE) && (pcpi_insn[14:12] <= F_CLEAR);

    // count[2] selects the row of C, count[1] the column, count[0] the inner-product term
    assign w_rowI = r_count[2];
    assign w_colJ = r_count[1];
    assign w_k    = r_count[0];
    assign w_aOp  = r_a[{w_rowI, w_k}];
    assign w_bOp  = r_b[{w_k, w_colJ}];
    assign w_prod = w_aOp * w_bOp;
    assign w_sum  = {{(ACC_W-PROD_W){r_acc[PROD_W-1]}}, r_acc}
                  + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

`ifdef MATMUL_SATURATE_EN
    logic [ACC_W-PROD_W:0] w_hiBits;
    logic                  w_ovf;
    assign w_hiBits = w_sum[ACC_W-1:PROD_W-1];
    assign w_ovf    = !((&w_hiBits) || (~|w_hiBits));
    assign w_cNew   = !w_ovf ? w_sum :
                      w_sum[ACC_W-1] ? {{(ACC_W-PROD_W+1){1'b1}}, {(PROD_W-1){1'b0}}}
                                     : {{(ACC_W-PROD_W+1){1'b0}}, {(PROD_W-1){1'b1}}};
`else
    assign w_cNew = w_sum;
`endif

    always_comb begin
        w_next      = r_state;
        pcpi_ready  = 1'b0;
        pcpi_wr     = 1'b0;
        pcpi_wait   = 1'b0;
        pcpi_rd     = 32'h0;
        busy        = (r_state != S_IDLE);
        err_illegal = r_err;
        case (r_state)
            S_IDLE: begin
                if (pcpi_valid && w_legal)
                    w_next = (pcpi_insn[14:12] == F_MUL) ? S_MAC : S_RESP;
            end
            S_MAC: begin
                pcpi_wait = 1'b1;
                if (r_count == 3'd7)
                    w_next = S_RESP;
            end
            S_RESP: begin
                pcpi_ready = 1'b1;
                w_next     = S_IDLE;
                if (r_funct3 == F_READC) begin
                    pcpi_wr = 1'b1;
                    pcpi_rd = {{(32-ACC_W){r_c[r_idx][ACC_W-1]}}, r_c[r_idx]};
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Instructions arriving while busy are dropped without flagging them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_funct3 <= 3'd0;
            r_idx    <= 2'd0;
            r_imm    <= '0;
            r_count  <= 3'd0;
            r_acc    <= '0;
            r_err    <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                r_a[n] <= '0;
                r_b[n] <= '0;
                r_c[n] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && pcpi_valid) begin
                if (w_legal) begin
                    r_funct3 <= pcpi_insn[14:12];
                    r_idx    <= pcpi_insn[16:15];
                    r_imm    <= pcpi_insn[24 +: DATA_W];
                    r_count  <= 3'd0;
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == S_MAC) begin
                r_count <= r_count + 3'd1;
                if (!w_k)
                    r_acc <= w_prod;
                else
                    r_c[{w_rowI, w_colJ}] <= w_cNew;
            end
            if (r_state == S_RESP) begin
                case (r_funct3)
                    F_LOADA: r_a[r_idx] <= r_imm;
                    F_LOADB: r_b[r_idx] <= r_imm;
                    F_CLEAR: begin
                        for (int n = 0; n < 4; n++) begin
                            r_a[n] <= '0;
                            r_b[n] <= '0;
                            r_c[n] <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcpi_matmul2x2.sv
// Self-checking bench for pcpi_matmul2x2: table of instruction/response vectors plus hand-written
// sequences for illegal instructions, valid-while-busy and reset in the middle of a MUL.
module tb_pcpi_matmul2x2;

    logic        clk;
    logic        rst;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic        pcpi_ready;
    logic        pcpi_wr;
    logic        pcpi_wait;
    logic [31:0] pcpi_rd;
    logic        busy;
    logic        err_illegal;

    int nChecks = 0;
    int nFails  = 0;

    localparam logic [2:0] F_LOADA = 3'b000;
    localparam logic [2:0] F_LOADB = 3'b001;
    localparam logic [2:0] F_MUL   = 3'b010;
    localparam logic [2:0] F_READC = 3'b011;
    localparam logic [2:0] F_CLEAR = 3'b100;

`ifdef MATMUL_SATURATE_EN
    localparam logic [31:0] T3_EXP = 32'h00007FFF;
`else
    localparam logic [31:0] T3_EXP = 32'h00008000;
`endif

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  idx;
        logic [7:0]  imm;
        int          expLat;
        int          expWait;
        logic        expWr;
        logic [31:0] expRd;
    } vec_t;

    vec_t vecs[$];

    pcpi_matmul2x2 dut (
        .clk         (clk),
        .rst         (rst),
        .pcpi_valid  (pcpi_valid),
        .pcpi_insn   (pcpi_insn),
        .pcpi_ready  (pcpi_ready),
        .pcpi_wr     (pcpi_wr),
        .pcpi_wait   (pcpi_wait),
        .pcpi_rd     (pcpi_rd),
        .busy        (busy),
        .err_illegal (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mkInsn(logic [2:0] f3, logic [1:0] idx, logic [7:0] imm);
        return {imm, 7'b0, idx, f3, 5'b0, 7'b0001011};
    endfunction

    function automatic void addVec(logic [2:0] f3, logic [1:0] idx, logic [7:0] imm, logic [31:0] expRd);
        vec_t v;
        v.f3      = f3;
        v.idx     = idx;
        v.imm     = imm;
        v.expLat  = (f3 == F_MUL) ? 9 : 1;
        v.expWait = (f3 == F_MUL) ? 8 : 0;
        v.expWr   = (f3 == F_READC);
        v.expRd   = (f3 == F_READC) ? expRd : 32'h0;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one instruction and follows it to ready, with a bounded wait
    task automatic applyStimulus(input logic [31:0] insn, output int lat, output int waits,
                                 output logic wr, output logic [31:0] rd);
        lat   = 0;
        waits = 0;
        wr    = 1'b0;
        rd    = 32'h0;
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = insn;
        @(negedge clk);
        pcpi_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (pcpi_ready) begin
                lat = n;
                wr  = pcpi_wr;
                rd  = pcpi_rd;
                break;
            end
            if (pcpi_wait) waits++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          lat;
        int          waits;
        logic        wr;
        logic [31:0] rd;
        logic        sawReady;
        logic        sawWait;

        // T1..T4 as a table
        addVec(F_READC, 2'd2, 8'd0, 32'h0);
        addVec(F_LOADA, 2'd0, 8'd1, 32'h0);
        addVec(F_LOADA, 2'd1, 8'd2, 32'h0);
        addVec(F_LOADA, 2'd2, 8'd3, 32'h0);
        addVec(F_LOADA, 2'd3, 8'd4, 32'h0);
        addVec(F_LOADB, 2'd0, 8'd5, 32'h0);
        addVec(F_LOADB, 2'd1, 8'd6, 32'h0);
        addVec(F_LOADB, 2'd2, 8'd7, 32'h0);
        addVec(F_LOADB, 2'd3, 8'd8, 32'h0);
        addVec(F_MUL,   2'd0, 8'd0, 32'h0);
        addVec(F_READC, 2'd0, 8'd0, 32'd19);
        addVec(F_READC, 2'd1, 8'd0, 32'd22);
        addVec(F_READC, 2'd2, 8'd0, 32'd43);
        addVec(F_READC, 2'd3, 8'd0, 32'd50);
        for (int n = 0; n < 4; n++) addVec(F_LOADA, n[1:0], 8'h80, 32'h0);
        for (int n = 0; n < 4; n++) addVec(F_LOADB, n[1:0], 8'h80, 32'h0);
        addVec(F_MUL,   2'd3, 8'd0, 32'h0);
        addVec(F_READC, 2'd0, 8'd0, T3_EXP);
        addVec(F_READC, 2'd3, 8'd0, T3_EXP);
        addVec(F_CLEAR, 2'd0, 8'd0, 32'h0);
        addVec(F_READC, 2'd3, 8'd0, 32'h0);
        addVec(F_LOADA, 2'd0, 8'hFD, 32'h0);
        addVec(F_LOADA, 2'd3, 8'd1, 32'h0);
        addVec(F_LOADB, 2'd0, 8'd1, 32'h0);
        addVec(F_LOADB, 2'd3, 8'd1, 32'h0);
        addVec(F_MUL,   2'd0, 8'd0, 32'h0);
        addVec(F_READC, 2'd0, 8'd0, 32'hFFFFFFFD);
        addVec(F_READC, 2'd3, 8'd0, 32'h00000001);
        addVec(F_READC, 2'd1, 8'd0, 32'h0);

        rst        = 1'b1;
        pcpi_valid = 1'b0;
        pcpi_insn  = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset ready", {31'b0, pcpi_ready}, 32'd0);
        checkOutput("reset wait",  {31'b0, pcpi_wait}, 32'd0);
        checkOutput("reset busy",  {31'b0, busy}, 32'd0);
        checkOutput("reset rd",    pcpi_rd, 32'd0);
        checkOutput("reset err",   {31'b0, err_illegal}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < vecs.size(); v++) begin
            applyStimulus(mkInsn(vecs[v].f3, vecs[v].idx, vecs[v].imm), lat, waits, wr, rd);
            checkOutput($sformatf("vec%0d latency", v), lat, vecs[v].expLat);
            checkOutput($sformatf("vec%0d waitCycles", v), waits, vecs[v].expWait);
            checkOutput($sformatf("vec%0d wr", v), {31'b0, wr}, {31'b0, vecs[v].expWr});
            checkOutput($sformatf("vec%0d rd", v), rd, vecs[v].expRd);
        end
        checkOutput("err after table", {31'b0, err_illegal}, 32'd0);

        // T6a: a valid pulse at MAC count=3 is dropped and does not flag illegal
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = mkInsn(F_MUL, 2'd0, 8'd0);
        @(negedge clk);
        pcpi_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            if (pcpi_ready) begin
                lat = n;
                break;
            end
            pcpi_valid = (n == 4);
            pcpi_insn  = (n == 4) ? 32'h00000013 : 32'h0;
            @(negedge clk);
        end
        pcpi_valid = 1'b0;
        checkOutput("busy-valid latency", lat, 32'd9);
        checkOutput("busy-valid err", {31'b0, err_illegal}, 32'd0);
        applyStimulus(mkInsn(F_READC, 2'd0, 8'd0), lat, waits, wr, rd);
        checkOutput("after T6a rd0", rd, 32'hFFFFFFFD);

        // T5: illegal opcode sets the sticky error and produces no response
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = 32'h00000013;
        @(negedge clk);
        pcpi_valid = 1'b0;
        sawReady = 1'b0;
        sawWait  = 1'b0;
        for (int n = 0; n < 10; n++) begin
            sawReady |= pcpi_ready;
            sawWait  |= pcpi_wait | busy;
            @(negedge clk);
        end
        checkOutput("illegal ready", {31'b0, sawReady}, 32'd0);
        checkOutput("illegal wait/busy", {31'b0, sawWait}, 32'd0);
        checkOutput("illegal err", {31'b0, err_illegal}, 32'd1);
        applyStimulus(mkInsn(F_READC, 2'd3, 8'd0), lat, waits, wr, rd);
        checkOutput("after illegal latency", lat, 32'd1);
        checkOutput("after illegal rd3", rd, 32'h00000001);
        checkOutput("err sticky", {31'b0, err_illegal}, 32'd1);

        // T6b: reset at MAC count=4 aborts the MUL and clears everything
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = mkInsn(F_MUL, 2'd0, 8'd0);
        @(negedge clk);
        pcpi_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("mid-MUL wait", {31'b0, pcpi_wait}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort ready", {31'b0, pcpi_ready}, 32'd0);
        checkOutput("abort wait",  {31'b0, pcpi_wait}, 32'd0);
        checkOutput("abort wr",    {31'b0, pcpi_wr}, 32'd0);
        checkOutput("abort rd",    pcpi_rd, 32'd0);
        checkOutput("abort busy",  {31'b0, busy}, 32'd0);
        checkOutput("abort err",   {31'b0, err_illegal}, 32'd0);
        rst = 1'b0;
        applyStimulus(mkInsn(F_READC, 2'd0, 8'd0), lat, waits, wr, rd);
        checkOutput("post-abort latency", lat, 32'd1);
        checkOutput("post-abort rd0", rd, 32'd0);
        applyStimulus(mkInsn(F_READC, 2'd3, 8'd0), lat, waits, wr, rd);
        checkOutput("post-abort rd3", rd, 32'd0);

        // funct3 = 101 with the right opcode is also illegal
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = mkInsn(3'b101, 2'd0, 8'd0);
        @(negedge clk);
        pcpi_valid = 1'b0;
        checkOutput("funct3 101 ready", {31'b0, pcpi_ready}, 32'd0);
        checkOutput("funct3 101 busy", {31'b0, busy}, 32'd0);
        checkOutput("funct3 101 err", {31'b0, err_illegal}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
